// File: rtl/squeeze_mac_engine.sv
// 1x1 squeeze-conv MAC engine: 8 filter lanes x 16 channels per cycle.
// Optional ReLU on the saturated result when SQUEEZE_RELU_EN is defined.
module squeeze_mac_engine #(
   parameter int FRAC  = 8,
   parameter int ACC_W = 48
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [2:0]    firesel,
   output logic          busy,
   output logic          done,
   output logic [31:0]   act_addr,
   input  logic [255:0]  act_data,
   output logic [31:0]   addressf1,
   output logic [31:0]   addressf2,
   output logic [31:0]   addressf3,
   output logic [31:0]   addressf4,
   output logic [31:0]   addressf5,
   output logic [31:0]   addressf6,
   output logic [31:0]   addressf7,
   output logic [31:0]   addressf8,
   input  logic [255:0]  dataf1,
   input  logic [255:0]  dataf2,
   input  logic [255:0]  dataf3,
   input  logic [255:0]  dataf4,
   input  logic [255:0]  dataf5,
   input  logic [255:0]  dataf6,
   input  logic [255:0]  dataf7,
   input  logic [255:0]  dataf8,
   output logic [31:0]   addressfiltf1,
   output logic [31:0]   addressfiltf2,
   output logic [31:0]   addressfiltf3,
   output logic [31:0]   addressfiltf4,
   output logic [31:0]   addressfiltf5,
   output logic [31:0]   addressfiltf6,
   output logic [31:0]   addressfiltf7,
   output logic [31:0]   addressfiltf8,
   input  logic [15:0]   biasf1,
   input  logic [15:0]   biasf2,
   input  logic [15:0]   biasf3,
   input  logic [15:0]   biasf4,
   input  logic [15:0]   biasf5,
   input  logic [15:0]   biasf6,
   input  logic [15:0]   biasf7,
   input  logic [15:0]   biasf8,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [127:0]  res_data,
   output logic [31:0]   res_filt
);

   typedef enum logic [2:0] {
      S_IDLE, S_MAC, S_BIAS, S_OUT, S_DONE
   } state_t;

   localparam logic signed [ACC_W-1:0] MAXV = 32767;
   localparam logic signed [ACC_W-1:0] MINV = -32768;

   state_t                   r_state;
   logic [2:0]               r_fsel;
   logic [31:0]              r_chunk;
   logic [31:0]              r_fbase;
   logic signed [ACC_W-1:0]  r_acc [8];
   logic                     r_busy;
   logic                     r_done;
   logic                     r_valid;
   logic [127:0]             r_res_data;
   logic [31:0]              r_res_filt;

   logic [255:0]             w_wd    [8];
   logic [15:0]              w_bias  [8];
   logic [31:0]              w_waddr [8];
   logic [31:0]              w_baddr [8];
   logic signed [31:0]       w_prod  [8][16];
   logic signed [ACC_W-1:0]  w_sum   [8];
   logic signed [ACC_W-1:0]  w_tot   [8];
   logic [15:0]              w_sat   [8];
   logic [15:0]              w_out   [8];
   logic [31:0]              w_cin;
   logic [31:0]              w_cout;
   logic [31:0]              w_last;
   logic                     w_addr_en;

   assign w_wd[0] = dataf1;
   assign w_wd[1] = dataf2;
   assign w_wd[2] = dataf3;
   assign w_wd[3] = dataf4;
   assign w_wd[4] = dataf5;
   assign w_wd[5] = dataf6;
   assign w_wd[6] = dataf7;
   assign w_wd[7] = dataf8;

   assign w_bias[0] = biasf1;
   assign w_bias[1] = biasf2;
   assign w_bias[2] = biasf3;
   assign w_bias[3] = biasf4;
   assign w_bias[4] = biasf5;
   assign w_bias[5] = biasf6;
   assign w_bias[6] = biasf7;
   assign w_bias[7] = biasf8;

   assign addressf1 = w_waddr[0];
   assign addressf2 = w_waddr[1];
   assign addressf3 = w_waddr[2];
   assign addressf4 = w_waddr[3];
   assign addressf5 = w_waddr[4];
   assign addressf6 = w_waddr[5];
   assign addressf7 = w_waddr[6];
   assign addressf8 = w_waddr[7];

   assign addressfiltf1 = w_baddr[0];
   assign addressfiltf2 = w_baddr[1];
   assign addressfiltf3 = w_baddr[2];
   assign addressfiltf4 = w_baddr[3];
   assign addressfiltf5 = w_baddr[4];
   assign addressfiltf6 = w_baddr[5];
   assign addressfiltf7 = w_baddr[6];
   assign addressfiltf8 = w_baddr[7];

   assign busy      = r_busy;
   assign done      = r_done;
   assign res_valid = r_valid;
   assign res_data  = r_res_data;
   assign res_filt  = r_res_filt;

   always_comb begin
      w_cin  = 32'd64;
      w_cout = 32'd16;
      unique case (r_fsel)
         3'd0: begin w_cin = 32'd64;  w_cout = 32'd16; end
         3'd1: begin w_cin = 32'd128; w_cout = 32'd16; end
         3'd2: begin w_cin = 32'd128; w_cout = 32'd32; end
         3'd3: begin w_cin = 32'd256; w_cout = 32'd32; end
         3'd4: begin w_cin = 32'd256; w_cout = 32'd48; end
         3'd5: begin w_cin = 32'd384; w_cout = 32'd48; end
         3'd6: begin w_cin = 32'd384; w_cout = 32'd64; end
         3'd7: begin w_cin = 32'd512; w_cout = 32'd64; end
      endcase
   end

   assign w_last    = (w_cin >> 4) - 32'd1;
   assign w_addr_en = (r_state == S_MAC) || (r_state == S_BIAS);
   assign act_addr  = w_addr_en ? (r_chunk << 4) : 32'd0;

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w_waddr[k] = '0;
         w_baddr[k] = '0;
         if (w_addr_en) begin
            w_waddr[k] = (r_fbase + 32'(k)) * w_cin + (r_chunk << 4);
            w_baddr[k] = r_fbase + 32'(k);
         end
      end
   end

   // Full-precision 16x16 products, sign-extended before summing.
   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w_sum[k] = '0;
         for (int i = 0; i < 16; i++) begin
            w_prod[k][i] = 32'($signed(w_wd[k][16*i +: 16]))
                         * 32'($signed(act_data[16*i +: 16]));
            w_sum[k] = w_sum[k] + ACC_W'(w_prod[k][i]);
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 8; k++) begin
         w_tot[k] = (r_acc[k] >>> FRAC) + ACC_W'($signed(w_bias[k]));
         if (w_tot[k] > MAXV)
            w_sat[k] = 16'h7FFF;
         else if (w_tot[k] < MINV)
            w_sat[k] = 16'h8000;
         else
            w_sat[k] = w_tot[k][15:0];
`ifdef SQUEEZE_RELU_EN
         w_out[k] = w_sat[k][15] ? 16'h0000 : w_sat[k];
`else
         w_out[k] = w_sat[k];
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_fsel     <= '0;
         r_chunk    <= '0;
         r_fbase    <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_valid    <= 1'b0;
         r_res_data <= '0;
         r_res_filt <= '0;
         for (int k = 0; k < 8; k++) r_acc[k] <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_MAC;
                  r_fsel  <= firesel;
                  r_chunk <= '0;
                  r_fbase <= '0;
                  r_busy  <= 1'b1;
                  for (int k = 0; k < 8; k++) r_acc[k] <= '0;
               end
            end
            S_MAC: begin
               for (int k = 0; k < 8; k++)
                  r_acc[k] <= r_acc[k] + w_sum[k];
               if (r_chunk == w_last)
                  r_state <= S_BIAS;
               else
                  r_chunk <= r_chunk + 32'd1;
            end
            S_BIAS: begin
               for (int k = 0; k < 8; k++)
                  r_res_data[16*k +: 16] <= w_out[k];
               r_res_filt <= r_fbase;
               r_valid    <= 1'b1;
               r_state    <= S_OUT;
            end
            S_OUT: begin
               if (res_ready) begin
                  r_valid <= 1'b0;
                  if (r_fbase + 32'd8 < w_cout) begin
                     r_fbase <= r_fbase + 32'd8;
                     r_chunk <= '0;
                     r_state <= S_MAC;
                     for (int k = 0; k < 8; k++) r_acc[k] <= '0;
                  end else begin
                     r_state <= S_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_squeeze_mac_engine.sv
// Directed self-checking bench for squeeze_mac_engine.
// Expectations follow SQUEEZE_RELU_EN when it is defined.
module tb_squeeze_mac_engine;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [2:0]    firesel = 3'd0;
   logic          busy;
   logic          done;
   logic [31:0]   act_addr;
   logic [255:0]  act_data = '0;
   logic [255:0]  wd = '0;
   logic [31:0]   af  [8];
   logic [31:0]   abf [8];
   logic [15:0]   bf  [8];
   logic          res_valid;
   logic          res_ready = 1'b0;
   logic [127:0]  res_data;
   logic [31:0]   res_filt;
   logic [15:0]   bias_c = '0;
   logic          bias_idx = 1'b0;

   int checks = 0;
   int errors = 0;

`ifdef SQUEEZE_RELU_EN
   localparam logic [15:0] NEG_EXP = 16'h0000;
   localparam logic [15:0] NSAT_EXP = 16'h0000;
`else
   localparam logic [15:0] NEG_EXP = 16'hC000;
   localparam logic [15:0] NSAT_EXP = 16'h8000;
`endif

   always #5 clk = ~clk;

   // Bias store model: either a constant or the filter index itself.
   always_comb begin
      for (int k = 0; k < 8; k++)
         bf[k] = bias_idx ? abf[k][15:0] : bias_c;
   end

   squeeze_mac_engine #(.FRAC(8), .ACC_W(48)) dut (
      .clk(clk), .rst(rst), .start(start), .firesel(firesel),
      .busy(busy), .done(done),
      .act_addr(act_addr), .act_data(act_data),
      .addressf1(af[0]), .addressf2(af[1]), .addressf3(af[2]),
      .addressf4(af[3]), .addressf5(af[4]), .addressf6(af[5]),
      .addressf7(af[6]), .addressf8(af[7]),
      .dataf1(wd), .dataf2(wd), .dataf3(wd), .dataf4(wd),
      .dataf5(wd), .dataf6(wd), .dataf7(wd), .dataf8(wd),
      .addressfiltf1(abf[0]), .addressfiltf2(abf[1]),
      .addressfiltf3(abf[2]), .addressfiltf4(abf[3]),
      .addressfiltf5(abf[4]), .addressfiltf6(abf[5]),
      .addressfiltf7(abf[6]), .addressfiltf8(abf[7]),
      .biasf1(bf[0]), .biasf2(bf[1]), .biasf3(bf[2]), .biasf4(bf[3]),
      .biasf5(bf[4]), .biasf6(bf[5]), .biasf7(bf[6]), .biasf8(bf[7]),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_data(res_data), .res_filt(res_filt)
   );

   function automatic logic [127:0] rep(input logic [15:0] v);
      return {8{v}};
   endfunction

   function automatic logic [127:0] idx_vec(input logic [15:0] base,
                                            input int fb);
      logic [127:0] r;
      for (int k = 0; k < 8; k++) r[16*k +: 16] = base + 16'(fb + k);
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [2:0] fs);
      firesel = fs;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_valid(input int budget, output bit ok);
      int n = 0;
      ok = 1'b0;
      while (!ok && n < budget) begin
         if (res_valid === 1'b1) ok = 1'b1;
         else begin tick(); n++; end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", res_valid); end
      checks++; if (res_data !== 128'd0) begin errors++; $display("FAIL rst_data got %h exp 0", res_data); end
      checks++; if (res_filt !== 32'd0) begin errors++; $display("FAIL rst_filt got %h exp 0", res_filt); end
      checks++; if (act_addr !== 32'd0) begin errors++; $display("FAIL rst_act got %h exp 0", act_addr); end
      checks++; if (af[7] !== 32'd0) begin errors++; $display("FAIL rst_af8 got %h exp 0", af[7]); end
      checks++; if (abf[7] !== 32'd0) begin errors++; $display("FAIL rst_abf8 got %h exp 0", abf[7]); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_basic();
      bit ok;
      wd = {16{16'h0100}};
      act_data = {16{16'h0100}};
      bias_c = 16'h0000;
      bias_idx = 1'b0;
      res_ready = 1'b0;
      pulse_start(3'd0);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
      repeat (4) tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b exp 0", res_valid); end
      tick();
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_lat_valid got %b exp 1", res_valid); end
      checks++; if (res_data !== rep(16'h4000)) begin errors++; $display("FAIL basic_g0_data got %h exp %h", res_data, rep(16'h4000)); end
      checks++; if (res_filt !== 32'd0) begin errors++; $display("FAIL basic_g0_filt got %0d exp 0", res_filt); end
      res_ready = 1'b1;
      tick();
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_accept got %b exp 0", res_valid); end
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_g1_timeout got %b exp 1", ok); end
      checks++; if (res_data !== rep(16'h4000)) begin errors++; $display("FAIL basic_g1_data got %h exp %h", res_data, rep(16'h4000)); end
      checks++; if (res_filt !== 32'd8) begin errors++; $display("FAIL basic_g1_filt got %0d exp 8", res_filt); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %b exp 0", busy); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b exp 0", done); end
      res_ready = 1'b0;
   endtask

   task automatic test_saturation();
      bit ok;
      wd = {16{16'h7FFF}};
      act_data = {16{16'h7FFF}};
      bias_c = 16'h7FFF;
      bias_idx = 1'b0;
      res_ready = 1'b1;
      pulse_start(3'd0);
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL sat_timeout got %b exp 1", ok); end
      checks++; if (res_data !== rep(16'h7FFF)) begin errors++; $display("FAIL sat_pos_data got %h exp %h", res_data, rep(16'h7FFF)); end
      tick();
      wait_valid(20, ok);
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL sat_done got %b exp 1", done); end
      tick();
      wd = {16{16'h8000}};
      bias_c = 16'h8000;
      pulse_start(3'd0);
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL nsat_timeout got %b exp 1", ok); end
      checks++; if (res_data !== rep(NSAT_EXP)) begin errors++; $display("FAIL nsat_data got %h exp %h", res_data, rep(NSAT_EXP)); end
      tick();
      wait_valid(20, ok);
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL nsat_done got %b exp 1", done); end
      tick();
   endtask

   task automatic test_negative();
      bit ok;
      wd = {16{16'hFF00}};
      act_data = {16{16'h0100}};
      bias_c = 16'h0000;
      bias_idx = 1'b0;
      res_ready = 1'b1;
      pulse_start(3'd0);
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL neg_timeout got %b exp 1", ok); end
      checks++; if (res_data !== rep(NEG_EXP)) begin errors++; $display("FAIL neg_data got %h exp %h", res_data, rep(NEG_EXP)); end
      tick();
      wait_valid(20, ok);
      checks++; if (res_data !== rep(NEG_EXP)) begin errors++; $display("FAIL neg_g1_data got %h exp %h", res_data, rep(NEG_EXP)); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL neg_done got %b exp 1", done); end
      tick();
   endtask

   task automatic test_addressing();
      res_ready = 1'b1;
      pulse_start(3'd7);
      firesel = 3'd0;
      repeat (107) tick();
      checks++; if (af[0] !== 32'd12368) begin errors++; $display("FAIL addr_f1 got %0d exp 12368", af[0]); end
      checks++; if (af[7] !== 32'd15952) begin errors++; $display("FAIL addr_f8 got %0d exp 15952", af[7]); end
      checks++; if (abf[7] !== 32'd31) begin errors++; $display("FAIL addr_filt8 got %0d exp 31", abf[7]); end
      checks++; if (act_addr !== 32'd80) begin errors++; $display("FAIL addr_act got %0d exp 80", act_addr); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic test_backpressure();
      bit ok;
      wd = {16{16'h0100}};
      act_data = {16{16'h0100}};
      bias_idx = 1'b1;
      res_ready = 1'b0;
      pulse_start(3'd0);
      wait_valid(20, ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout got %b exp 1", ok); end
      for (int i = 0; i < 10; i++) begin
         checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got %b exp 1", i, res_valid); end
         checks++; if (res_data !== idx_vec(16'h4000, 0)) begin errors++; $display("FAIL bp_data[%0d] got %h exp %h", i, res_data, idx_vec(16'h4000, 0)); end
         checks++; if (res_filt !== 32'd0) begin errors++; $display("FAIL bp_filt[%0d] got %0d exp 0", i, res_filt); end
         checks++; if (af[0] !== 32'd0 || abf[0] !== 32'd0 || act_addr !== 32'd0) begin errors++; $display("FAIL bp_addr[%0d] got %h/%h/%h exp 0", i, af[0], abf[0], act_addr); end
         tick();
      end
      res_ready = 1'b1;
      tick();
      checks++; if (af[0] !== 32'd512) begin errors++; $display("FAIL bp_next_af1 got %0d exp 512", af[0]); end
      checks++; if (abf[0] !== 32'd8) begin errors++; $display("FAIL bp_next_filt1 got %0d exp 8", abf[0]); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_next_valid got %b exp 0", res_valid); end
      wait_valid(20, ok);
      checks++; if (res_data !== idx_vec(16'h4000, 8)) begin errors++; $display("FAIL bp_g1_data got %h exp %h", res_data, idx_vec(16'h4000, 8)); end
      checks++; if (res_filt !== 32'd8) begin errors++; $display("FAIL bp_g1_filt got %0d exp 8", res_filt); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done); end
      tick();
   endtask

   task automatic test_reset_mid_pass();
      int cyc;
      int g;
      int done_cyc;
      bit seen;
      wd = {16{16'h0040}};
      act_data = {16{16'h0100}};
      bias_idx = 1'b1;
      res_ready = 1'b1;
      pulse_start(3'd3);
      repeat (7) tick();
      checks++; if (act_addr !== 32'd112) begin errors++; $display("FAIL mid_act got %0d exp 112", act_addr); end
      rst = 1'b1;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b exp 0", busy); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", res_valid); end
      checks++; if (act_addr !== 32'd0 || af[0] !== 32'd0 || abf[0] !== 32'd0) begin errors++; $display("FAIL mid_rst_addr got %h/%h/%h exp 0", act_addr, af[0], abf[0]); end
      tick();
      rst = 1'b0;
      tick();
      pulse_start(3'd3);
      cyc = 0;
      g = 0;
      done_cyc = -1;
      seen = 1'b0;
      while (!seen && cyc < 200) begin
         if (res_valid === 1'b1) begin
            checks++; if (res_data !== idx_vec(16'h4000, g*8)) begin errors++; $display("FAIL rerun_data[%0d] got %h exp %h", g, res_data, idx_vec(16'h4000, g*8)); end
            checks++; if (res_filt !== 32'(g*8)) begin errors++; $display("FAIL rerun_filt[%0d] got %0d exp %0d", g, res_filt, g*8); end
            g++;
         end
         if (done === 1'b1) begin
            seen = 1'b1;
            done_cyc = cyc;
         end else begin
            start = (cyc == 3);
            tick();
            start = 1'b0;
            cyc++;
         end
      end
      checks++; if (g !== 4) begin errors++; $display("FAIL rerun_groups got %0d exp 4", g); end
      checks++; if (done_cyc !== 72) begin errors++; $display("FAIL rerun_done_cycle got %0d exp 72", done_cyc); end
      tick();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired got timeout exp finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_saturation();
      test_negative();
      test_addressing();
      test_backpressure();
      test_reset_mid_pass();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
